// File: rtl/motor_pwm_decoder.sv
// Decodes one motor channel's fwd/rev PWM pin pair into a signed speed once per PWM window.
// Optional build macro PWM_SYNC_EN puts a 2-flop synchronizer on the pins before sampling.
//   state | meaning
//   IDLE  | not measuring, counters clear, outputs hold
//   MEAS  | sampling fwd/rev once per clk, window of PERIOD clks
module motor_pwm_decoder #(
  parameter int PERIOD  = 1024,
  parameter int SPEED_W = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_fwd,
  input  logic               i_rev,
  output logic [SPEED_W-1:0] o_spd,
  output logic               o_spd_vld,
  output logic               o_brake,
  output logic               o_coast,
  output logic               o_dir_err
);

  localparam int WW  = $clog2(PERIOD);
  localparam int CW  = WW + 1;
  localparam int MAX = 2 ** (SPEED_W - 1) - 1;

  typedef enum logic {IDLE, MEAS} state_t;

  state_t          r_state;
  logic [WW-1:0]   r_win;
  logic [CW-1:0]   r_fcnt, r_rcnt, r_bcnt;
  logic [CW-1:0]   r_ffin, r_rfin, r_bfin;
  logic            r_eval;

  logic            w_fwd, w_rev;
  logic            w_f_hit, w_r_hit, w_b_hit;
  int              w_f, w_r, w_d;
  logic [SPEED_W-1:0] w_spd;
  logic            w_brk, w_cst, w_derr;

`ifdef PWM_SYNC_EN
  logic [1:0] r_fwd_sync, r_rev_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fwd_sync <= 2'b00;
      r_rev_sync <= 2'b00;
    end else begin
      r_fwd_sync <= {r_fwd_sync[0], i_fwd};
      r_rev_sync <= {r_rev_sync[0], i_rev};
    end
  end

  assign w_fwd = r_fwd_sync[1];
  assign w_rev = r_rev_sync[1];
`else
  assign w_fwd = i_fwd;
  assign w_rev = i_rev;
`endif

  assign w_f_hit = w_fwd & ~w_rev;
  assign w_r_hit = ~w_fwd & w_rev;
  assign w_b_hit = w_fwd & w_rev;

  // Result of the window latched in the *_fin registers, in priority order.
  always_comb begin
    w_f    = int'(r_ffin);
    w_r    = int'(r_rfin);
    w_d    = w_f - w_r;
    w_spd  = '0;
    w_brk  = 1'b0;
    w_cst  = 1'b0;
    w_derr = 1'b0;
    if (r_bfin == CW'(PERIOD)) begin
      w_brk = 1'b1;
    end else if (w_f == 0 && w_r == 0) begin
      w_cst = 1'b1;
    end else if (w_r == 0) begin
      w_spd = SPEED_W'((w_f > MAX) ? MAX : w_f);
    end else if (w_f == 0) begin
      w_spd = SPEED_W'(-((w_r > MAX) ? MAX : w_r));
    end else begin
      w_derr = 1'b1;
      w_spd  = SPEED_W'((w_d > MAX) ? MAX : ((w_d < -MAX) ? -MAX : w_d));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_win     <= '0;
      r_fcnt    <= '0;
      r_rcnt    <= '0;
      r_bcnt    <= '0;
      r_ffin    <= '0;
      r_rfin    <= '0;
      r_bfin    <= '0;
      r_eval    <= 1'b0;
      o_spd     <= '0;
      o_spd_vld <= 1'b0;
      o_brake   <= 1'b0;
      o_coast   <= 1'b0;
      o_dir_err <= 1'b0;
    end else begin
      o_spd_vld <= 1'b0;
      // A completed window reports on the edge after its last sample, even if en just fell.
      if (r_eval) begin
        r_eval    <= 1'b0;
        o_spd     <= w_spd;
        o_brake   <= w_brk;
        o_coast   <= w_cst;
        o_dir_err <= w_derr;
        o_spd_vld <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_win  <= '0;
          r_fcnt <= '0;
          r_rcnt <= '0;
          r_bcnt <= '0;
          if (i_en) r_state <= MEAS;
        end
        MEAS: begin
          if (!i_en) begin
            r_state <= IDLE;
            r_win   <= '0;
            r_fcnt  <= '0;
            r_rcnt  <= '0;
            r_bcnt  <= '0;
          end else begin
            r_win <= r_win + WW'(1);
            if (r_win == WW'(PERIOD - 1)) begin
              r_ffin <= r_fcnt + CW'(w_f_hit);
              r_rfin <= r_rcnt + CW'(w_r_hit);
              r_bfin <= r_bcnt + CW'(w_b_hit);
              r_fcnt <= '0;
              r_rcnt <= '0;
              r_bcnt <= '0;
              r_eval <= 1'b1;
            end else begin
              r_fcnt <= r_fcnt + CW'(w_f_hit);
              r_rcnt <= r_rcnt + CW'(w_r_hit);
              r_bcnt <= r_bcnt + CW'(w_b_hit);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_pwm_decoder.sv
// Scoreboard bench for motor_pwm_decoder: driver pushes expected window results, monitor checks them.
module tb_motor_pwm_decoder;

  localparam int PERIOD  = 1024;
  localparam int SPEED_W = 11;
  localparam int MAX     = 2 ** (SPEED_W - 1) - 1;

  logic               clk = 1'b0;
  logic               rst, en, fwd, rev;
  logic [SPEED_W-1:0] spd;
  logic               spd_vld, brake, coast, dir_err;

  motor_pwm_decoder #(.PERIOD(PERIOD), .SPEED_W(SPEED_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_fwd(fwd), .i_rev(rev),
    .o_spd(spd), .o_spd_vld(spd_vld), .o_brake(brake), .o_coast(coast),
    .o_dir_err(dir_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SPEED_W-1:0] spd;
    logic               brake, coast, derr;
    int                 cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       last_exp;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         base    = 0;
  int         win_k   = 0;
  logic [1:0] pat [PERIOD];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: counts sample kinds over the whole pattern, then applies the result rules.
  function automatic exp_t model();
    exp_t m;
    int f = 0, r = 0, b = 0, v;
    for (int i = 0; i < PERIOD; i++) begin
      if (pat[i] == 2'b10) f++;
      if (pat[i] == 2'b01) r++;
      if (pat[i] == 2'b11) b++;
    end
    m.spd = '0; m.brake = 1'b0; m.coast = 1'b0; m.derr = 1'b0; m.cyc = 0;
    if (b == PERIOD) m.brake = 1'b1;
    else if (f == 0 && r == 0) m.coast = 1'b1;
    else begin
      v = f - r;
      if (f > 0 && r > 0) m.derr = 1'b1;
      if (v > MAX) v = MAX;
      if (v < -MAX) v = -MAX;
      m.spd = SPEED_W'(v);
    end
    return m;
  endfunction

  task automatic fill(input int nf, input int nr, input int nb, input bit shuffle);
    logic [1:0] t;
    int j;
    for (int i = 0; i < PERIOD; i++)
      pat[i] = (i < nf) ? 2'b10 : (i < nf + nr) ? 2'b01 : (i < nf + nr + nb) ? 2'b11 : 2'b00;
    if (shuffle)
      for (int i = 0; i < PERIOD; i++) begin
        j = $urandom_range(PERIOD - 1);
        t = pat[i]; pat[i] = pat[j]; pat[j] = t;
      end
  endtask

  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      {fwd, rev} = pat[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic enable();
    en = 1'b1;
    base = cyc;
    win_k = 0;
    @(posedge clk); #1;
  endtask

  // Full window; first result lands PERIOD+1 edges after the IDLE->MEAS edge, then every PERIOD.
  task automatic window(input exp_t e);
    drive(PERIOD);
    e.cyc = base + PERIOD + 2 + win_k * PERIOD;
    q.push_back(e);
    win_k++;
  endtask

  function automatic exp_t mk(input int s, input bit b, input bit c, input bit d);
    exp_t e;
    e.spd = SPEED_W'(s); e.brake = b; e.coast = c; e.derr = d; e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (spd_vld) begin
      if (q.size() == 0) begin
        chk("unexpected_spd_vld", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("vld_cycle", cyc, e.cyc);
        chk("spd", int'(spd), int'(e.spd));
        chk("brake", int'(brake), int'(e.brake));
        chk("coast", int'(coast), int'(e.coast));
        chk("dir_err", int'(dir_err), int'(e.derr));
        last_exp = e;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf, nr, nb;
    rst = 1'b1; en = 1'b0; fwd = 1'b0; rev = 1'b0;
    last_exp = mk(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_spd", int'(spd), 0);
    chk("reset_vld", int'(spd_vld), 0);
    chk("reset_flags", int'({brake, coast, dir_err}), 0);
    repeat (5) @(posedge clk);
    #1;

    enable();
    fill(512, 0, 0, 0);   window(mk(11'h200, 0, 0, 0));
    fill(512, 0, 0, 0);   window(mk(11'h200, 0, 0, 0));
    fill(0, 100, 0, 0);   window(mk(11'h79C, 0, 0, 0));
    fill(0, 0, PERIOD, 0); window(mk(0, 1, 0, 0));
    fill(0, 0, 0, 0);     window(mk(0, 0, 1, 0));
    fill(PERIOD, 0, 0, 0); window(mk(11'h3FF, 0, 0, 0));
    fill(0, PERIOD, 0, 0); window(mk(11'h401, 0, 0, 0));
    fill(300, 200, 0, 0); window(mk(11'h064, 0, 0, 1));
    fill(0, 0, 700, 1);   window(mk(0, 0, 1, 0));
    fill(0, 0, PERIOD - 1, 0); window(mk(0, 0, 1, 0));
    for (int w = 0; w < 6; w++) begin
      nf = $urandom_range(PERIOD);
      nr = (w % 2 == 0) ? $urandom_range(PERIOD - nf) : 0;
      nb = $urandom_range(PERIOD - nf - nr);
      fill(nf, nr, nb, 1);
      window(model());
    end

    // Abort mid-window: no result, outputs hold the last reported window.
    fill(400, 0, 0, 0);
    drive(600);
    en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_empty_q", q.size(), 0);
    chk("hold_spd", int'(spd), int'(last_exp.spd));
    chk("hold_flags", int'({brake, coast, dir_err}),
        int'({last_exp.brake, last_exp.coast, last_exp.derr}));

    enable();
    fill(0, 37, 5, 1);    window(mk(-37, 0, 0, 0));
    fill(200, 0, 0, 0);
    drive(300);
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_spd", int'(spd), 0);
    chk("rst_vld", int'(spd_vld), 0);
    chk("rst_flags", int'({brake, coast, dir_err}), 0);
    repeat (PERIOD + 20) @(posedge clk);
    #1;
    chk("final_empty_q", q.size(), 0);
    chk("final_spd", int'(spd), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
